// File: rtl/ft_recovery_ctrl_if.sv
// Lockstep recovery bundle: comparator inputs, restore write port and status outputs.
// Latency: none, wiring only.
// Backpressure: none; the cores must honour halt_o.
//
// Ports
//   commit_i / error_i   comparator strobe and mismatch flag (core side -> controller)
//   backup_rdata_i       golden register file read data at rf_addr_o
//   halt_o               stall both cores
//   rf_we_o / rf_addr_o / rf_data_o   restore write port into both register files
//   rollback_o           one-cycle PC rollback request
//   busy_o / fatal_o     sequencer status; fatal is sticky until reset
//   retry_cnt_o          recoveries since the last clean stretch
//   err_count_o          total detected errors (zero unless the counter is built)
//
// Modports: master = recovery controller, slave = lockstep pair / backup file.
interface ft_recovery_ctrl_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_RETRY  = 3
);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  logic                  commit_i;
  logic                  error_i;
  logic [DATA_WIDTH-1:0] backup_rdata_i;
  logic                  halt_o;
  logic                  rf_we_o;
  logic [ADDR_WIDTH-1:0] rf_addr_o;
  logic [DATA_WIDTH-1:0] rf_data_o;
  logic                  rollback_o;
  logic                  busy_o;
  logic                  fatal_o;
  logic [RETRY_W-1:0]    retry_cnt_o;
  logic [15:0]           err_count_o;

  modport master (
    input  commit_i, error_i, backup_rdata_i,
    output halt_o, rf_we_o, rf_addr_o, rf_data_o, rollback_o,
           busy_o, fatal_o, retry_cnt_o, err_count_o
  );

  modport slave (
    output commit_i, error_i, backup_rdata_i,
    input  halt_o, rf_we_o, rf_addr_o, rf_data_o, rollback_o,
           busy_o, fatal_o, retry_cnt_o, err_count_o
  );
endinterface

// File: rtl/ft_recovery_ctrl.sv
// Lockstep recovery sequencer: halt, drain, restore x1..xN-1 from the golden file, roll back PC.
// Latency: halt_o rises 1 cycle after a mismatch, falls 1+DRAIN_CYCLES+(NUM_REGS-1)+1 cycles after it.
// Backpressure: none accepted; the cores are stalled through halt_o for the whole recovery.
//
// Ports
//   clk_i, rst_ni   clock and asynchronous active-low reset
//   rif (master)    comparator inputs, restore write port, rollback and status (see ft_recovery_ctrl_if)
//
// Build option: define FT_ERR_COUNTER_EN to build the 16-bit saturating detected-error counter
// behind err_count_o; without it err_count_o is tied to zero and no counter flops exist.
module ft_recovery_ctrl #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REGS     = 32,
  parameter int DRAIN_CYCLES = 4,
  parameter int MAX_RETRY    = 3,
  parameter int GOOD_COMMITS = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  ft_recovery_ctrl_if.master  rif
);

  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam int GOOD_W  = $clog2(GOOD_COMMITS + 1);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  localparam logic [RETRY_W-1:0]    RETRY_MAX  = RETRY_W'(MAX_RETRY);
  localparam logic [GOOD_W-1:0]     GOOD_LAST  = GOOD_W'(GOOD_COMMITS - 1);
  localparam logic [DRAIN_W-1:0]    DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_FIRST = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(NUM_REGS - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HALT    = 3'd1;
  localparam logic [2:0] ST_RESTORE = 3'd2;
  localparam logic [2:0] ST_RESUME  = 3'd3;
  localparam logic [2:0] ST_FATAL   = 3'd4;

  logic [2:0]            state_q,    state_d;
  logic [DRAIN_W-1:0]    drain_q,    drain_d;
  logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic [RETRY_W-1:0]    retry_q,    retry_d;
  logic [GOOD_W-1:0]     good_q,     good_d;
  logic                  halt_q,     halt_d;
  logic                  rf_we_q,    rf_we_d;
  logic                  rollback_q, rollback_d;
  logic                  busy_q,     busy_d;
  logic                  fatal_q,    fatal_d;

  // Sequencer and counters. Comparator activity only matters in IDLE: while
  // the cores are halted any strobe is an artefact of the stall itself.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    addr_d  = addr_q;
    retry_d = retry_q;
    good_d  = good_q;

    case (state_q)
      ST_IDLE: begin
        if (rif.commit_i && rif.error_i) begin
          good_d = '0;
          if (retry_q == RETRY_MAX) begin
            state_d = ST_FATAL;
          end else begin
            // retry_q < RETRY_MAX here, so the count cannot wrap.
            retry_d = retry_q + 1'b1;
            drain_d = '0;
            state_d = ST_HALT;
          end
        end else if (rif.commit_i) begin
          if (good_q == GOOD_LAST) begin
            good_d  = '0;
            retry_d = '0;
          end else begin
            good_d = good_q + 1'b1;
          end
        end
      end

      ST_HALT: begin
        if (drain_q == DRAIN_LAST) begin
          drain_d = '0;
          addr_d  = ADDR_FIRST;   // x0 is hard-wired zero, never rewritten
          state_d = ST_RESTORE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end

      ST_RESTORE: begin
        if (addr_q == ADDR_LAST) begin
          // Park the address at zero so rf_addr_o reads 0 outside RESTORE.
          addr_d  = '0;
          state_d = ST_RESUME;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end

      ST_RESUME: state_d = ST_IDLE;

      ST_FATAL:  state_d = ST_FATAL;

      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state
  // register and leave the block straight from flops.
  always_comb begin
    halt_d     = (state_d != ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
    rf_we_d    = (state_d == ST_RESTORE);
    rollback_d = (state_d == ST_RESUME);
    fatal_d    = (state_d == ST_FATAL);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      drain_q    <= '0;
      addr_q     <= '0;
      retry_q    <= '0;
      good_q     <= '0;
      halt_q     <= 1'b0;
      rf_we_q    <= 1'b0;
      rollback_q <= 1'b0;
      busy_q     <= 1'b0;
      fatal_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      addr_q     <= addr_d;
      retry_q    <= retry_d;
      good_q     <= good_d;
      halt_q     <= halt_d;
      rf_we_q    <= rf_we_d;
      rollback_q <= rollback_d;
      busy_q     <= busy_d;
      fatal_q    <= fatal_d;
    end
  end

  assign rif.halt_o      = halt_q;
  assign rif.rf_we_o     = rf_we_q;
  assign rif.rf_addr_o   = addr_q;
  assign rif.rollback_o  = rollback_q;
  assign rif.busy_o      = busy_q;
  assign rif.fatal_o     = fatal_q;
  assign rif.retry_cnt_o = retry_q;

  // The golden file is read combinationally at rf_addr_o, so the write data
  // follows it in the same cycle; forced to zero when not writing.
  assign rif.rf_data_o = rf_we_q ? rif.backup_rdata_i : '0;

`ifdef FT_ERR_COUNTER_EN
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        det_evt;

  // Counts every mismatch taken in IDLE, including the one that escalates to FATAL.
  assign det_evt = (state_q == ST_IDLE) && rif.commit_i && rif.error_i;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (det_evt && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign rif.err_count_o = err_cnt_q;
`else
  assign rif.err_count_o = '0;
`endif

endmodule

// File: tb/tb_ft_recovery_ctrl.sv
// Scoreboard bench for ft_recovery_ctrl: randomized comparator traffic against a timeline model.
// Latency: expectations are queued per cycle and per restore beat, popped by a negedge monitor.
// Backpressure: not applicable; the bench only drives the comparator strobes.
module tb_ft_recovery_ctrl;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NREG  = 32;
  localparam int DRAIN = 4;
  localparam int MAXR  = 3;
  localparam int GOOD  = 16;
  // Offsets, in cycles after the cycle the mismatch is presented.
  localparam int FIRST_WR = 1 + DRAIN;               // 5
  localparam int LAST_WR  = DRAIN + NREG - 1;        // 35
  localparam int RB_AT    = DRAIN + NREG;            // 36
  localparam int IDLE_AT  = DRAIN + NREG + 1;        // 37

`ifdef FT_ERR_COUNTER_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    int          cyc;
    logic        halt;
    logic        we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic        rb;
    logic        busy;
    logic        fatal;
    logic [1:0]  retry;
    logic [15:0] errc;
  } exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [DW-1:0] golden [NREG];

  exp_t  sb [$];
  beat_t wq [$];
  exp_t  mon_e;
  beat_t mon_b;

  // Reference model state.
  int m_retry;
  int m_good;
  int m_errs;
  bit m_fatal;
  int last_e;

  ft_recovery_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_RETRY(MAXR)) rif ();

  ft_recovery_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NREG),
    .DRAIN_CYCLES(DRAIN), .MAX_RETRY(MAXR), .GOOD_COMMITS(GOOD)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .rif    (rif.master)
  );

  assign rif.backup_rdata_i = golden[rif.rf_addr_o];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit m_idle(input int c);
    return !m_fatal && (c >= last_e + IDLE_AT);
  endfunction

  task automatic model_reset();
    m_retry = 0;
    m_good  = 0;
    m_errs  = 0;
    m_fatal = 0;
    last_e  = -1000;
    sb.delete();
    wq.delete();
  endtask

  // Present one cycle of comparator input, update the model, queue what the
  // DUT must show in the following cycle, then advance to just after the edge.
  task automatic drive(input bit c, input bit e);
    exp_t r;
    int   n;
    rif.commit_i = c;
    rif.error_i  = e;
    if (m_idle(cyc)) begin
      if (c && e) begin
        if (ERR_EN && m_errs < 16'hFFFF) m_errs++;
        m_good = 0;
        if (m_retry == MAXR) begin
          m_fatal = 1;
        end else begin
          m_retry++;
          last_e = cyc;
          for (int k = 1; k < NREG; k++) golden[k] = $urandom;
          for (int k = 1; k < NREG; k++) begin
            beat_t b;
            b.addr = AW'(k);
            b.data = golden[k];
            wq.push_back(b);
          end
        end
      end else if (c) begin
        m_good++;
        if (m_good == GOOD) begin
          m_good  = 0;
          m_retry = 0;
        end
      end
    end
    n       = cyc + 1;
    r.cyc   = n;
    r.halt  = m_fatal || (n >= last_e + 1 && n <= last_e + RB_AT);
    r.busy  = r.halt;
    r.fatal = m_fatal;
    r.we    = (n >= last_e + FIRST_WR) && (n <= last_e + LAST_WR);
    r.addr  = r.we ? AW'(n - last_e - DRAIN) : '0;
    r.data  = r.we ? golden[r.addr] : '0;
    r.rb    = (n == last_e + RB_AT);
    r.retry = 2'(m_retry);
    r.errc  = 16'(m_errs);
    sb.push_back(r);
    @(posedge clk);
    #1;
  endtask

  // Random strobes while the model says a recovery is in flight; bounded by
  // the recovery length and skipped entirely once fatal.
  task automatic wait_idle();
    while (!m_fatal && cyc < last_e + IDLE_AT)
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rif.commit_i = 1'b0;
    rif.error_i  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_halt"},     rif.halt_o,      0);
    chk({tag, "_we"},       rif.rf_we_o,     0);
    chk({tag, "_addr"},     rif.rf_addr_o,   0);
    chk({tag, "_data"},     rif.rf_data_o,   0);
    chk({tag, "_rollback"}, rif.rollback_o,  0);
    chk({tag, "_busy"},     rif.busy_o,      0);
    chk({tag, "_fatal"},    rif.fatal_o,     0);
    chk({tag, "_retry"},    rif.retry_cnt_o, 0);
    chk({tag, "_errcnt"},   rif.err_count_o, 0);
  endtask

  // Monitor: per-cycle status record plus one restore beat per rf_we_o.
  always @(negedge clk) begin
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) void'(sb.pop_front());
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        mon_e = sb.pop_front();
        chk("halt",      rif.halt_o,      mon_e.halt);
        chk("rf_we",     rif.rf_we_o,     mon_e.we);
        chk("rf_addr",   rif.rf_addr_o,   mon_e.addr);
        chk("rf_data",   rif.rf_data_o,   mon_e.data);
        chk("rollback",  rif.rollback_o,  mon_e.rb);
        chk("busy",      rif.busy_o,      mon_e.busy);
        chk("fatal",     rif.fatal_o,     mon_e.fatal);
        chk("retry_cnt", rif.retry_cnt_o, mon_e.retry);
        chk("err_count", rif.err_count_o, mon_e.errc);
      end
      if (rif.rf_we_o) begin
        chk("beat_pending", 64'(wq.size() > 0), 1);
        if (wq.size() > 0) begin
          mon_b = wq.pop_front();
          chk("beat_addr", rif.rf_addr_o, mon_b.addr);
          chk("beat_data", rif.rf_data_o, mon_b.data);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int e0;
    rif.commit_i = 1'b0;
    rif.error_i  = 1'b0;
    for (int k = 0; k < NREG; k++) golden[k] = $urandom;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Single recovery, then strobes that must be ignored.
    drive(1, 1);
    wait_idle();
    repeat (10) drive(0, 1);
    drive(1, 1);
    wait_idle();

    // Four back-to-back mismatches: three recoveries, then sticky FATAL.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1);
      wait_idle();
    end
    repeat (25) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Clean-commit window: 16 clears the retry count, 15 does not.
    do_reset();
    drive(1, 1);
    wait_idle();
    repeat (GOOD) drive(1, 0);
    drive(1, 1);
    wait_idle();
    repeat (GOOD - 1) drive(1, 0);
    drive(1, 1);
    wait_idle();
    drive(0, 0);

    // Five separated recoveries for the error counter.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 1);
      wait_idle();
      repeat (GOOD) drive(1, 0);
    end

    // Asynchronous reset in the middle of RESTORE at x10.
    do_reset();
    drive(1, 1);
    e0 = last_e;
    while (cyc < e0 + DRAIN + 10) drive(0, 0);
    chk("midrestore_addr", rif.rf_addr_o, 10);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("post_reset_busy",  rif.busy_o,      0);
    chk("post_reset_retry", rif.retry_cnt_o, 0);
    repeat (40) drive(0, 0);

    // Randomized traffic; restart from reset whenever the model goes fatal.
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      int r;
      if (m_fatal && $urandom_range(0, 9) == 0) do_reset();
      r = $urandom_range(0, 99);
      if (r < 3)       drive(1, 1);
      else if (r < 65) drive(1, 0);
      else if (r < 80) drive(0, 1);
      else             drive(0, 0);
    end
    wait_idle();
    drive(0, 0);
    drive(0, 0);
    chk("beats_drained", wq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
